// File: rtl/transpose_ctrl.sv
// transpose_ctrl: sequencing controller for a NUM_MG-bank memory used to transpose
// NUM_MG x NUM_MG tiles.
//
// Rows are written one per beat with a diagonal skew: row r, column j lands in bank
// (j + r) mod NUM_MG at address r. Columns are then read back one per beat. Every bank
// is read once per column, so there are no bank conflicts.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  input row handshake; in_row[j] is column j of the row
//   wen, waddr      memory write enable / per-bank write address
//   write_elements  per-bank write data (row rotated by the row index)
//   ren, raddr      memory read enable / per-bank read address
//   read_elements   memory read data, valid the cycle after ren, held until next ren
//   out_valid/ready output column handshake; out_col[r] is source row r
//   tile_done       one-cycle pulse on the last output handshake of a tile
//   tile_count      (TRANSPOSE_TILE_CNT_EN only) number of completed tiles, wraps at 2^32
//
// Optional feature macro: TRANSPOSE_TILE_CNT_EN
module transpose_ctrl #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_MG     = 8,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_MG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_row         [0:NUM_MG-1],
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr          [0:NUM_MG-1],
  output logic [DATA_WIDTH-1:0] write_elements [0:NUM_MG-1],
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] raddr          [0:NUM_MG-1],
  input  logic [DATA_WIDTH-1:0] read_elements  [0:NUM_MG-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_col        [0:NUM_MG-1],
  output logic                  tile_done
`ifdef TRANSPOSE_TILE_CNT_EN
  ,
  output logic [31:0]           tile_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NUM_MG - 1);

  typedef enum logic [1:0] {StWrite, StRead, StDrain} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   row_cnt_q;
  logic [ADDR_WIDTH-1:0]   col_cnt_q;
  logic [ADDR_WIDTH-1:0]   col_q;
  logic                    rd_pend_q;
  logic                    in_hs;
  logic                    out_hs;

  assign in_ready  = (state_q == StWrite);
  assign in_hs     = in_valid && in_ready;
  assign wen       = in_hs;
  assign out_valid = rd_pend_q;
  assign out_hs    = out_valid && out_ready;
  // A new read may only overwrite read_elements once the held column is consumed.
  assign ren       = (state_q == StRead) && (!out_valid || out_ready);
  assign tile_done = (state_q == StDrain) && out_hs;

  // Index arithmetic wraps by truncation to ADDR_WIDTH bits.
  always_comb begin
    for (int b = 0; b < NUM_MG; b++) begin
      waddr[b]          = row_cnt_q;
      write_elements[b] = in_row[ADDR_WIDTH'(ADDR_WIDTH'(b) - row_cnt_q)];
      raddr[b]          = (state_q == StRead) ? ADDR_WIDTH'(ADDR_WIDTH'(b) - col_cnt_q)
                                              : '0;
      // Row r of column col_q sits in bank (col_q + r).
      out_col[b]        = read_elements[ADDR_WIDTH'(col_q + ADDR_WIDTH'(b))];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StWrite;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      col_q     <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      // A fresh issue keeps the output pending even if the held column is consumed now.
      if (ren) begin
        rd_pend_q <= 1'b1;
      end else if (out_hs) begin
        rd_pend_q <= 1'b0;
      end

      unique case (state_q)
        StWrite: begin
          if (in_hs) begin
            row_cnt_q <= row_cnt_q + 1'b1;
            if (row_cnt_q == LastIdx) state_q <= StRead;
          end
        end
        StRead: begin
          if (ren) begin
            col_q     <= col_cnt_q;
            col_cnt_q <= col_cnt_q + 1'b1;
            if (col_cnt_q == LastIdx) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (out_hs) state_q <= StWrite;
        end
        default: state_q <= StWrite;
      endcase
    end
  end

`ifdef TRANSPOSE_TILE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_count <= '0;
    end else if (tile_done) begin
      tile_count <= tile_count + 32'd1;
    end
  end
`endif

endmodule
